// File: rtl/eval_requester_pkg.sv
// Shared types and constants for the evaluator requester.
// Square code: bits [2:0] piece type, bit 3 set for black.
package eval_requester_pkg;

   localparam int PIECE_WIDTH = 4;
   localparam int SQUARES     = 64;
   localparam int BOARD_WIDTH = PIECE_WIDTH * SQUARES;

   localparam int PHASE_MAX = 24;
   localparam int PHASE_W   = 5;

   localparam logic [3:0] PIECE_KNIGHT = 4'd2;
   localparam logic [3:0] PIECE_BISHOP = 4'd3;
   localparam logic [3:0] PIECE_ROOK   = 4'd4;
   localparam logic [3:0] PIECE_QUEEN  = 4'd5;
   localparam logic [3:0] PIECE_BLACK  = 4'd8;

   localparam logic [2:0] WEIGHT_MINOR = 3'd1;
   localparam logic [2:0] WEIGHT_ROOK  = 3'd2;
   localparam logic [2:0] WEIGHT_QUEEN = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_EVAL,
      S_CLEAR,
      S_DRAIN,
      S_RESULT
   } state_t;

   function automatic logic [2:0] phase_weight(input logic [3:0] sq);
      logic [2:0] w;
      w = 3'd0;
      case (sq)
         PIECE_KNIGHT, PIECE_KNIGHT | PIECE_BLACK,
         PIECE_BISHOP, PIECE_BISHOP | PIECE_BLACK: w = WEIGHT_MINOR;
         PIECE_ROOK,   PIECE_ROOK   | PIECE_BLACK: w = WEIGHT_ROOK;
         PIECE_QUEEN,  PIECE_QUEEN  | PIECE_BLACK: w = WEIGHT_QUEEN;
         default:                                  w = 3'd0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/eval_requester_board_phase.sv
// Game-phase count of a board: minor 1, rook 2, queen 4, both colours,
// saturated at PHASE_MAX and registered.
module board_phase
   import eval_requester_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [BOARD_WIDTH-1:0] board,
   output logic [PHASE_W-1:0]     phase
);

   logic [9:0] sum;

   always_comb begin
      sum = '0;
      for (int i = 0; i < SQUARES; i++) begin
         sum = sum + 10'(phase_weight(board[i*PIECE_WIDTH +: PIECE_WIDTH]));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase <= '0;
      end else if (sum > 10'(PHASE_MAX)) begin
         phase <= PHASE_W'(PHASE_MAX);
      end else begin
         phase <= sum[PHASE_W-1:0];
      end
   end

endmodule

// File: rtl/eval_requester.sv
// Initiator side of the evaluator handshake: launches one board, captures
// the evaluation and returns a phase-tapered side-to-move score.
module eval_requester
   import eval_requester_pkg::*;
#(
   parameter int EVAL_WIDTH     = 24,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [BOARD_WIDTH-1:0]       req_board,
   input  logic                         req_white_to_move,
   output logic [BOARD_WIDTH-1:0]       board,
   output logic                         board_valid,
   output logic                         white_to_move,
   output logic                         clear_eval,
   input  logic                         eval_valid,
   input  logic signed [EVAL_WIDTH-1:0] eval_mg,
   input  logic signed [EVAL_WIDTH-1:0] eval_eg,
   input  logic signed [31:0]           material,
   input  logic                         insufficient_material,
   output logic                         result_valid,
   input  logic                         result_ack,
   output logic signed [EVAL_WIDTH+5:0] result_score,
   output logic signed [31:0]           result_material,
   output logic                         result_draw,
   output logic                         result_timeout
);

   localparam int BW = EVAL_WIDTH + 5;
   localparam int SW = EVAL_WIDTH + 6;
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   state_t state, state_nxt;

   logic [CW-1:0]              tcnt;
   logic [PHASE_W-1:0]         phase;
   logic [PHASE_W-1:0]         ephase;
   logic signed [EVAL_WIDTH-1:0] mg_r, eg_r;
   logic signed [31:0]         mat_r;
   logic                       draw_r, tout_r;
   logic signed [BW-1:0]       mg_x, eg_x, ph_x, ep_x;
   logic signed [BW-1:0]       blend_c, blend_r;
   logic signed [SW-1:0]       score_c;
   logic                       load_req, cap_eval, do_timeout, load_res;

   board_phase u_phase (
      .clk   (clk),
      .reset (reset),
      .board (board),
      .phase (phase)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      req_ready    = 1'b0;
      board_valid  = 1'b0;
      clear_eval   = 1'b0;
      result_valid = 1'b0;
      load_req     = 1'b0;
      cap_eval     = 1'b0;
      do_timeout   = 1'b0;
      load_res     = 1'b0;
      unique case (state)
         S_IDLE: begin
            req_ready = !reset;
            if (req_valid) begin
               load_req  = 1'b1;
               state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            board_valid = 1'b1;
            state_nxt   = S_WAIT_EVAL;
         end
         S_WAIT_EVAL: begin
            board_valid = 1'b1;
            if (eval_valid) begin
               cap_eval  = 1'b1;
               state_nxt = S_CLEAR;
            end else if (tcnt == CW'(TIMEOUT_CYCLES - 1)) begin
               do_timeout = 1'b1;
               state_nxt  = S_CLEAR;
            end
         end
         S_CLEAR: begin
            clear_eval = 1'b1;
            state_nxt  = S_DRAIN;
         end
         S_DRAIN: begin
            if (!eval_valid) begin
               load_res  = 1'b1;
               state_nxt = S_RESULT;
            end
         end
         S_RESULT: begin
            result_valid = 1'b1;
            if (result_ack) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Cycles since board_valid rose; LAUNCH counts as the first.
   always_ff @(posedge clk) begin
      if (reset || state == S_IDLE) tcnt <= '0;
      else if (board_valid)         tcnt <= tcnt + 1'b1;
   end

   assign ephase  = PHASE_W'(PHASE_MAX) - phase;
   assign mg_x    = BW'(mg_r);
   assign eg_x    = BW'(eg_r);
   assign ph_x    = BW'(phase);
   assign ep_x    = BW'(ephase);
   assign blend_c = mg_x * ph_x + eg_x * ep_x;

   always_comb begin
      score_c = '0;
      if (!(draw_r || tout_r)) begin
         score_c = white_to_move ? SW'(blend_r) : -SW'(blend_r);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         board           <= '0;
         white_to_move   <= 1'b0;
         mg_r            <= '0;
         eg_r            <= '0;
         mat_r           <= '0;
         draw_r          <= 1'b0;
         tout_r          <= 1'b0;
         blend_r         <= '0;
         result_score    <= '0;
         result_material <= '0;
         result_draw     <= 1'b0;
         result_timeout  <= 1'b0;
      end else begin
         if (load_req) begin
            board         <= req_board;
            white_to_move <= req_white_to_move;
         end
         if (cap_eval) begin
            mg_r   <= eval_mg;
            eg_r   <= eval_eg;
            mat_r  <= material;
            draw_r <= insufficient_material;
            tout_r <= 1'b0;
         end
         if (do_timeout) begin
            mg_r   <= '0;
            eg_r   <= '0;
            mat_r  <= '0;
            draw_r <= 1'b0;
            tout_r <= 1'b1;
         end
         // Product registered while the evaluator is being released.
         if (state == S_CLEAR || state == S_DRAIN) blend_r <= blend_c;
         if (load_res) begin
            result_score    <= score_c;
            result_material <= mat_r;
            result_draw     <= draw_r;
            result_timeout  <= tout_r;
         end
      end
   end

endmodule

// File: tb/tb_eval_requester.sv
// Directed bench for eval_requester with an evaluator stub and a
// score model computed from piece counts.
module tb_eval_requester;
   import eval_requester_pkg::*;

   localparam int EW = 24;

   localparam logic [3:0] PP  = 4'd1;
   localparam logic [3:0] PN  = 4'd2;
   localparam logic [3:0] PB  = 4'd3;
   localparam logic [3:0] PR  = 4'd4;
   localparam logic [3:0] PQ  = 4'd5;
   localparam logic [3:0] PK  = 4'd6;
   localparam logic [3:0] BLK = 4'd8;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   req_valid = 1'b0;
   logic                   req_ready;
   logic [BOARD_WIDTH-1:0] req_board = '0;
   logic                   req_white_to_move = 1'b0;
   logic [BOARD_WIDTH-1:0] board;
   logic                   board_valid;
   logic                   white_to_move;
   logic                   clear_eval;
   logic                   eval_valid;
   logic signed [EW-1:0]   eval_mg = '0;
   logic signed [EW-1:0]   eval_eg = '0;
   logic signed [31:0]     material = '0;
   logic                   insufficient_material = 1'b0;
   logic                   result_valid;
   logic                   result_ack = 1'b0;
   logic signed [EW+5:0]   result_score;
   logic signed [31:0]     result_material;
   logic                   result_draw;
   logic                   result_timeout;

   eval_requester #(.EVAL_WIDTH(EW), .TIMEOUT_CYCLES(64)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .req_valid             (req_valid),
      .req_ready             (req_ready),
      .req_board             (req_board),
      .req_white_to_move     (req_white_to_move),
      .board                 (board),
      .board_valid           (board_valid),
      .white_to_move         (white_to_move),
      .clear_eval            (clear_eval),
      .eval_valid            (eval_valid),
      .eval_mg               (eval_mg),
      .eval_eg               (eval_eg),
      .material              (material),
      .insufficient_material (insufficient_material),
      .result_valid          (result_valid),
      .result_ack            (result_ack),
      .result_score          (result_score),
      .result_material       (result_material),
      .result_draw           (result_draw),
      .result_timeout        (result_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   function automatic void chk(string nm, longint act, longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   // Evaluator stub: result 7 cycles after board_valid rises, dropped
   // 2 cycles after clear_eval.
   logic stub_en = 1'b1;
   logic bv_q;
   logic clr_q;
   int   lat_cnt;

   always @(posedge clk) begin
      if (reset) begin
         bv_q       <= 1'b0;
         clr_q      <= 1'b0;
         lat_cnt    <= 0;
         eval_valid <= 1'b0;
      end else begin
         bv_q <= board_valid;
         if (board_valid && !bv_q && stub_en) lat_cnt <= 6;
         else if (lat_cnt != 0)               lat_cnt <= lat_cnt - 1;
         if (lat_cnt == 1) eval_valid <= 1'b1;
         if (clear_eval) clr_q <= 1'b1;
         if (clr_q) begin
            eval_valid <= 1'b0;
            clr_q      <= 1'b0;
         end
      end
   end

   // Model
   logic [BOARD_WIDTH-1:0] exp_board = '0;
   logic                   exp_wtm = 1'b0;
   longint                 exp_score = 0;
   longint                 exp_mat = 0;
   logic                   exp_draw = 1'b0;
   logic                   exp_to = 1'b0;
   logic                   busy = 1'b0;

   function automatic int model_phase(logic [BOARD_WIDTH-1:0] b);
      int minors = 0, rooks = 0, queens = 0, ph;
      for (int sq = 0; sq < 64; sq++) begin
         case (b[sq*4 +: 3])
            3'd2, 3'd3: minors++;
            3'd4:       rooks++;
            3'd5:       queens++;
            default: ;
         endcase
      end
      ph = minors + 2 * rooks + 4 * queens;
      return (ph > 24) ? 24 : ph;
   endfunction

   function automatic longint model_score(logic [BOARD_WIDTH-1:0] b,
         bit wtm, longint mg, longint eg, bit zero);
      int ph = model_phase(b);
      longint blend = mg * ph + eg * (24 - ph);
      if (zero) return 0;
      return wtm ? blend : -blend;
   endfunction

   function automatic logic [BOARD_WIDTH-1:0] put(
         logic [BOARD_WIDTH-1:0] b, int sq, logic [3:0] p);
      b[sq*4 +: 4] = p;
      return b;
   endfunction

   function automatic logic [BOARD_WIDTH-1:0] start_board();
      logic [BOARD_WIDTH-1:0] b = '0;
      logic [3:0] back [8] = '{PR, PN, PB, PQ, PK, PB, PN, PR};
      for (int f = 0; f < 8; f++) begin
         b = put(b, f, back[f]);
         b = put(b, 8 + f, PP);
         b = put(b, 48 + f, PP | BLK);
         b = put(b, 56 + f, back[f] | BLK);
      end
      return b;
   endfunction

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (!reset) begin
         if (busy) begin
            chk("busy_ready", req_ready, 0);
         end else begin
            chk("idle_ready", req_ready, 1);
            chk("idle_result_valid", result_valid, 0);
         end
         if (result_valid) begin
            chk("score", result_score, exp_score);
            chk("material", result_material, exp_mat);
            chk("draw", result_draw, exp_draw);
            chk("timeout", result_timeout, exp_to);
         end
         if (board_valid) begin
            n_checks++;
            if (board !== exp_board || white_to_move !== exp_wtm) begin
               n_errors++;
               $display("FAIL board: got side %0b expected side %0b or board differs",
                        white_to_move, exp_wtm);
            end
         end
      end
   end

   task automatic send_req(input logic [BOARD_WIDTH-1:0] b, input bit wtm);
      int w = 0;
      @(negedge clk);
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) chk("ready_wait", 0, 1);
      exp_board         = b;
      exp_wtm           = wtm;
      req_board         = b;
      req_white_to_move = wtm;
      req_valid         = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      busy      = 1'b1;
   endtask

   task automatic run_req(input logic [BOARD_WIDTH-1:0] b, input bit wtm,
         input bit respond, input longint mg, input longint eg,
         input longint mat, input bit draw, input int ack_hold,
         output int lat, output int bvc, output int clrc);
      stub_en               = respond;
      eval_mg               = EW'(mg);
      eval_eg               = EW'(eg);
      material              = 32'(mat);
      insufficient_material = draw;
      exp_score = model_score(b, wtm, mg, eg, draw || !respond);
      exp_mat   = respond ? mat : 0;
      exp_draw  = respond && draw;
      exp_to    = !respond;
      send_req(b, wtm);
      lat = 0; bvc = 0; clrc = 0;
      do begin
         @(negedge clk);
         lat++;
         bvc  += int'(board_valid);
         clrc += int'(clear_eval);
      end while (!result_valid && lat < 300);
      if (!result_valid) chk("result_wait", lat, -1);
      for (int i = 0; i < ack_hold; i++) @(negedge clk);
      result_ack = 1'b1;
      @(posedge clk);
      #1;
      result_ack = 1'b0;
      busy       = 1'b0;
      @(negedge clk);
      chk("ack_release", result_valid, 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_board_valid"}, board_valid, 0);
      chk({tag, "_clear_eval"}, clear_eval, 0);
      chk({tag, "_result_valid"}, result_valid, 0);
      chk({tag, "_score"}, result_score, 0);
      chk({tag, "_material"}, result_material, 0);
      chk({tag, "_draw"}, result_draw, 0);
      chk({tag, "_timeout"}, result_timeout, 0);
      chk({tag, "_wtm"}, white_to_move, 0);
      chk({tag, "_board_zero"}, longint'(board == '0), 1);
   endtask

   initial begin
      logic [BOARD_WIDTH-1:0] sb, rb, qb, sat;
      int lat, bvc, clrc;

      sb = start_board();
      rb = put(put(put('0, 4, PK), 60, PK | BLK), 0, PR);
      qb = put(put(put(put('0, 4, PK), 60, PK | BLK), 59, PQ | BLK), 1, PN);
      sat = sb;
      for (int f = 0; f < 8; f++) sat = put(sat, 8 + f, PQ);

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      chk("phase_start", model_phase(sb), 24);
      chk("phase_rook", model_phase(rb), 2);
      chk("phase_queen", model_phase(qb), 5);
      chk("phase_sat", model_phase(sat), 24);

      run_req(sb, 1, 1, 50, 30, 0, 0, 0, lat, bvc, clrc);
      chk("t1_model", exp_score, 1200);
      chk("t1_latency", lat, 12);
      chk("t1_bv_cycles", bvc, 8);
      chk("t1_clear_pulses", clrc, 1);

      run_req(sb, 0, 1, 50, 30, 0, 0, 2, lat, bvc, clrc);
      chk("t2_model", exp_score, -1200);

      run_req(rb, 1, 1, 500, 600, 500, 0, 1, lat, bvc, clrc);
      chk("t3_model", exp_score, 14200);

      run_req(sb, 1, 1, 0, 0, 0, 1, 0, lat, bvc, clrc);
      chk("t4_draw", result_draw, 1);

      run_req(sb, 0, 1, 100, -40, -300, 1, 0, lat, bvc, clrc);
      chk("t4b_model", exp_score, 0);

      run_req(sat, 1, 1, 10, -7, 77, 0, 0, lat, bvc, clrc);
      chk("t5_model", exp_score, 240);

      run_req(sb, 1, 0, 50, 30, 9, 0, 0, lat, bvc, clrc);
      chk("t6_timeout", result_timeout, 1);
      chk("t6_bv_cycles", bvc, 64);
      chk("t6_clear_pulses", clrc, 1);
      chk("t6_latency", lat, 67);

      // Abandon a transaction with reset while waiting on the evaluator.
      stub_en = 1'b1;
      eval_mg = 24'sd50;
      eval_eg = 24'sd30;
      send_req(sb, 1);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      busy  = 1'b0;
      @(posedge clk);
      #1;
      check_all_zero("midreset");
      @(negedge clk);
      reset = 1'b0;

      run_req(qb, 0, 1, -200, 80, -900, 0, 10, lat, bvc, clrc);
      chk("t7_model", exp_score, -520);
      chk("t7_latency", lat, 12);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
